// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared CPU definitions for instruction fetch and decode
package fetch_unit_pkg;

   localparam int OPCODE_W    = 24;
   localparam int INSTR_BYTES = 3;

   typedef enum logic [2:0] {
      ST_RESET  = 3'd0,
      ST_FETCH0 = 3'd1,
      ST_FETCH1 = 3'd2,
      ST_FETCH2 = 3'd3,
      ST_READY  = 3'd4
   } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - byte-serial fetch of 3-byte instructions with jump redirect
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int                ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                clk,
   input  logic                rst,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic                mem_rd,
   input  logic [7:0]          mem_data,
   input  logic                mem_ack,
   output logic [OPCODE_W-1:0] opcode,
   output logic                op_rdy,
   input  logic                pc_en,
   input  logic                jump_en,
   input  logic [ADDR_W-1:0]   jump_addr,
   output logic [ADDR_W-1:0]   pc
);

   fetch_state_t          state, state_next;
   logic [ADDR_W-1:0]     pc_next;
   logic [OPCODE_W-1:0]   opcode_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_RESET;
         pc     <= RESET_PC;
         opcode <= '0;
      end else begin
         state  <= state_next;
         pc     <= pc_next;
         opcode <= opcode_next;
      end
   end

   always_comb begin
      state_next  = state;
      pc_next     = pc;
      opcode_next = opcode;
      mem_rd      = 1'b0;
      mem_addr    = pc;
      op_rdy      = 1'b0;

      case (state)
         ST_RESET: begin
            state_next = ST_FETCH0;
         end
         ST_FETCH0: begin
            mem_rd = 1'b1;
            if (mem_ack) begin
               opcode_next[23:16] = mem_data;
               state_next         = ST_FETCH1;
            end
         end
         ST_FETCH1: begin
            mem_rd   = 1'b1;
            mem_addr = pc + ADDR_W'(1);
            if (mem_ack) begin
               opcode_next[15:8] = mem_data;
               state_next        = ST_FETCH2;
            end
         end
         ST_FETCH2: begin
            mem_rd   = 1'b1;
            mem_addr = pc + ADDR_W'(2);
            if (mem_ack) begin
               opcode_next[7:0] = mem_data;
               state_next       = ST_READY;
            end
         end
         ST_READY: begin
            op_rdy = 1'b1;
            if (pc_en) begin
               pc_next    = pc + ADDR_W'(INSTR_BYTES);
               state_next = ST_FETCH0;
            end
         end
         default: begin
            state_next = ST_RESET;
         end
      endcase

      // A redirect wins over both an ack and an accept; any byte landing this cycle is dropped.
      if (jump_en && state != ST_RESET) begin
         pc_next     = jump_addr;
         state_next  = ST_FETCH0;
         opcode_next = opcode;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

   logic        clk;
   logic        rst;
   logic [15:0] mem_addr;
   logic        mem_rd;
   logic [7:0]  mem_data;
   logic        mem_ack;
   logic [23:0] opcode;
   logic        op_rdy;
   logic        pc_en;
   logic        jump_en;
   logic [15:0] jump_addr;
   logic [15:0] pc;

   int vecs = 0;
   int errs = 0;

   fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
      .clk       (clk),
      .rst       (rst),
      .mem_addr  (mem_addr),
      .mem_rd    (mem_rd),
      .mem_data  (mem_data),
      .mem_ack   (mem_ack),
      .opcode    (opcode),
      .op_rdy    (op_rdy),
      .pc_en     (pc_en),
      .jump_en   (jump_en),
      .jump_addr (jump_addr),
      .pc        (pc)
   );

   // Memory model: byte = lo*0x11 + hi; bus carries junk while no ack is given.
   logic [7:0] mem_byte;
   assign mem_byte = mem_addr[7:0] * 8'h11 + mem_addr[15:8];
   assign mem_data = mem_ack ? mem_byte : 8'hEE;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      // reset with every other input active: all must be ignored
      rst = 1'b1; pc_en = 1'b1; jump_en = 1'b1; jump_addr = 16'h1234; mem_ack = 1'b1;
      tick; tick;
      chk("rst_op_rdy", op_rdy, 0);
      chk("rst_mem_rd", mem_rd, 0);
      chk("rst_pc", pc, 16'h0000);
      chk("rst_opcode", opcode, 24'h000000);
      chk("rst_mem_addr", mem_addr, 16'h0000);

      // first fetch, ack tied high, pc_en high while idle
      rst = 1'b0; jump_en = 1'b0;
      tick;
      chk("f0_addr", mem_addr, 16'h0000);
      chk("f0_rd", mem_rd, 1);
      chk("f0_rdy", op_rdy, 0);
      tick;
      chk("f1_addr", mem_addr, 16'h0001);
      chk("f1_rdy", op_rdy, 0);
      tick;
      chk("f2_addr", mem_addr, 16'h0002);
      chk("f2_rdy", op_rdy, 0);
      tick;
      pc_en = 1'b0;
      chk("rdy_op_rdy", op_rdy, 1);
      chk("rdy_opcode", opcode, 24'h001122);
      chk("rdy_mem_rd", mem_rd, 0);
      chk("rdy_pc", pc, 16'h0000);

      // decoder stalls five cycles
      for (int i = 0; i < 5; i++) begin
         tick;
         chk("hold_rdy", op_rdy, 1);
         chk("hold_opcode", opcode, 24'h001122);
      end
      pc_en = 1'b1;
      tick;
      chk("accept_pc", pc, 16'h0003);
      chk("accept_addr", mem_addr, 16'h0003);
      chk("accept_rd", mem_rd, 1);
      chk("accept_rdy", op_rdy, 0);

      // wait states in FETCH1
      tick;
      chk("f1b_addr", mem_addr, 16'h0004);
      mem_ack = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick;
         chk("wait_addr", mem_addr, 16'h0004);
         chk("wait_rd", mem_rd, 1);
         chk("wait_rdy", op_rdy, 0);
      end
      mem_ack = 1'b1;
      tick;
      chk("after_wait_addr", mem_addr, 16'h0005);
      tick;
      chk("wait_opcode", opcode, 24'h334455);
      chk("wait_op_rdy", op_rdy, 1);

      // jump beats pc_en in READY
      jump_en = 1'b1; jump_addr = 16'h0050;
      tick;
      chk("jr_pc", pc, 16'h0050);
      chk("jr_addr", mem_addr, 16'h0050);
      chk("jr_rdy", op_rdy, 0);
      jump_en = 1'b0;
      tick;
      tick;
      chk("pre_jf2_addr", mem_addr, 16'h0052);

      // jump beats mem_ack in FETCH2
      jump_en = 1'b1; jump_addr = 16'h0100;
      tick;
      chk("jf2_addr", mem_addr, 16'h0100);
      chk("jf2_pc", pc, 16'h0100);
      chk("jf2_rdy", op_rdy, 0);
      chk("jf2_rd", mem_rd, 1);
      jump_en = 1'b0;
      tick;
      chk("jf2_f1_addr", mem_addr, 16'h0101);
      tick; tick;
      chk("jf2_opcode", opcode, 24'h011223);
      chk("jf2_op_rdy", op_rdy, 1);

      // address wrap at the top of memory
      jump_en = 1'b1; jump_addr = 16'hFFFE;
      tick;
      chk("wrap_a0", mem_addr, 16'hFFFE);
      jump_en = 1'b0;
      tick;
      chk("wrap_a1", mem_addr, 16'hFFFF);
      tick;
      chk("wrap_a2", mem_addr, 16'h0000);
      tick;
      chk("wrap_opcode", opcode, 24'hDDEE00);
      chk("wrap_pc", pc, 16'hFFFE);
      tick;
      chk("wrap_next_pc", pc, 16'h0001);
      chk("wrap_next_addr", mem_addr, 16'h0001);

      // reset mid-fetch
      tick;
      chk("pre_rst_addr", mem_addr, 16'h0002);
      rst = 1'b1;
      tick;
      chk("rstf_op_rdy", op_rdy, 0);
      chk("rstf_mem_rd", mem_rd, 0);
      chk("rstf_pc", pc, 16'h0000);
      chk("rstf_opcode", opcode, 24'h000000);

      // reset while an instruction is ready
      rst = 1'b0; pc_en = 1'b0;
      tick; tick; tick; tick;
      chk("rr_op_rdy", op_rdy, 1);
      chk("rr_opcode", opcode, 24'h001122);
      rst = 1'b1;
      tick;
      chk("rstr_op_rdy", op_rdy, 0);
      chk("rstr_mem_rd", mem_rd, 0);
      chk("rstr_pc", pc, 16'h0000);
      chk("rstr_opcode", opcode, 24'h000000);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
